// File: rtl/mem_arbiter.sv
// Purpose : two-port (fetch/data) arbiter in front of a single-outstanding memory port.
// Latency : grant combinational in IDLE; rvalid two cycles after grant at best; abort after TIMEOUT access cycles.
// Backpr. : requesters hold req until gnt; no grant while an access is outstanding.
//
// Ports:
//   clock/reset            : single clock, synchronous active-high reset
//   if_req/if_addr/if_gnt  : fetch request side, if_rvalid pulses on completion
//   d_req/d_we/d_addr/...  : data request side, d_rvalid pulses on completion (read or write)
//   rdata/err              : completion payload, held between rvalid pulses
//   mem_*                  : memory port; mem_ready ends an access, ignored in IDLE
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    // Counter value seen during the last allowed access cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_if_rvalid;
    logic              r_d_rvalid;

    logic              w_gnt_if;
    logic              w_gnt_d;
    logic              w_done_ok;
    logic              w_done_to;
    logic              w_done;

    // mem_ready on the final allowed cycle still counts as success.
    assign w_done_ok = (r_state == ST_ACCESS) && mem_ready;
    assign w_done_to = (r_state == ST_ACCESS) && !mem_ready && (r_cnt == CNT_LAST);
    assign w_done    = w_done_ok || w_done_to;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (if_req || d_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_done)          w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: grants and memory strobes
    always_comb begin
        w_gnt_if = 1'b0;
        w_gnt_d  = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        if ((r_state == ST_IDLE) && !reset) begin
            if (if_req && d_req) begin
                // Whoever was not served last wins the conflict.
                if (r_last_owner == OWN_IF) begin
                    w_gnt_d = 1'b1;
                end else begin
                    w_gnt_if = 1'b1;
                end
            end else begin
                w_gnt_if = if_req;
                w_gnt_d  = d_req;
            end
        end
        if (r_state == ST_ACCESS) begin
            mem_en = 1'b1;
            mem_we = r_we;
        end
    end

    assign if_gnt    = w_gnt_if;
    assign d_gnt     = w_gnt_d;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;

    // Request capture, access counter and completion registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (w_gnt_if || w_gnt_d) begin
                r_owner      <= w_gnt_d;
                r_last_owner <= w_gnt_d;
                r_addr       <= w_gnt_d ? d_addr : if_addr;
                r_we         <= w_gnt_d && d_we;
                r_wdata      <= w_gnt_d ? d_wdata : '0;
                r_cnt        <= '0;
            end
            if (r_state == ST_ACCESS) begin
                if (w_done) begin
                    r_if_rvalid <= (r_owner == OWN_IF);
                    r_d_rvalid  <= (r_owner == OWN_D);
                    r_rdata     <= (w_done_ok && !r_we) ? mem_rdata : '0;
                    r_err       <= w_done_to;
                    r_cnt       <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : scoreboard bench for mem_arbiter with a transaction-level reference model.
// Latency : checks grant owner, completion payload and grant-to-rvalid cycle count.
// Backpr. : requesters hold req until gnt; memory responder applies per-transaction latency.
module tb_mem_arbiter;

    localparam int TO = 16;

    typedef struct {
        bit          own;    // 0 fetch, 1 data
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;  // value expected on mem_wdata
        logic [31:0] mdata;  // value memory returns with mem_ready
        int          lat;    // access cycle on which memory answers (> TO: never)
    } txn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, err, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   m_last = 1'b0;  // model: owner granted most recently
    txn_t exp_q[$];
    txn_t mem_q[$];
    bit   gexp_q[$];
    int   gcyc_q[$];

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int acc_cycles(input txn_t t);
        return (t.lat > TO) ? TO : t.lat;
    endfunction

    function automatic logic [31:0] exp_rdata(input txn_t t);
        if (t.lat > TO || t.we) return 32'h0;
        return t.mdata;
    endfunction

    function automatic txn_t mk(input bit own, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] mdata, input int lat);
        txn_t t;
        t.own = own; t.we = we; t.addr = addr; t.wdata = wdata; t.mdata = mdata; t.lat = lat;
        return t;
    endfunction

    function automatic txn_t rnd_txn(input bit own);
        txn_t t;
        t.own   = own;
        t.we    = own ? 1'($urandom) : 1'b0;
        t.addr  = $urandom;
        t.wdata = own ? $urandom : 32'h0;
        t.mdata = $urandom;
        t.lat   = ($urandom % 5 == 0) ? int'($urandom_range(TO + 2, TO - 2)) : int'($urandom_range(4, 1));
        return t;
    endfunction

    function automatic void push(input txn_t t);
        exp_q.push_back(t);
        mem_q.push_back(t);
        gexp_q.push_back(t.own);
    endfunction

    // Present one or both requests simultaneously, hold each until granted.
    // Called and returns at posedge+1.
    task automatic issue(input bit use_f, input bit use_d, input txn_t tf, input txn_t td,
                         output int d_wait);
        bit fp, dp, gf, gd;
        int budget;
        if (use_f && use_d) begin
            if (m_last == 1'b0) begin push(td); push(tf); m_last = 1'b0; end
            else                begin push(tf); push(td); m_last = 1'b1; end
        end else if (use_f) begin
            push(tf); m_last = 1'b0;
        end else if (use_d) begin
            push(td); m_last = 1'b1;
        end
        fp = use_f; dp = use_d; d_wait = 0; budget = 400;
        if (use_f) begin if_req = 1'b1; if_addr = tf.addr; end
        if (use_d) begin d_req = 1'b1; d_we = td.we; d_addr = td.addr; d_wdata = td.wdata; end
        while ((fp || dp) && budget > 0) begin
            @(negedge clock);
            if (dp) d_wait++;
            gf = fp && if_gnt;
            gd = dp && d_gnt;
            @(posedge clock); #1;
            if (gf) begin fp = 1'b0; if_req = 1'b0; if_addr = $urandom; end
            if (gd) begin
                dp = 1'b0; d_req = 1'b0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
            end
            budget--;
        end
        check("grant_wait", {62'd0, fp, dp}, 64'd0);
    endtask

    task automatic drain();
        int b = 400;
        while (exp_q.size() != 0 && b > 0) begin @(posedge clock); #1; b--; end
        check("drain", exp_q.size(), 0);
    endtask

    // Memory responder: answers each access on its transaction's latency.
    initial begin : responder
        txn_t cur;
        bit   act = 1'b0;
        int   n   = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        cur = mk(0, 0, 0, 0, 0, 1);
        forever begin
            @(negedge clock);
            if (reset) begin
                act = 1'b0;
                mem_ready = 1'b0;
            end else if (mem_en) begin
                if (!act) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", 1, 0);
                        cur = mk(0, 0, mem_addr, mem_wdata, 0, 1);
                    end else begin
                        cur = mem_q.pop_front();
                    end
                    act = 1'b1;
                    n   = 0;
                end
                n++;
                check("mem_addr", mem_addr, cur.addr);
                check("mem_we", mem_we, cur.we);
                check("mem_wdata", mem_wdata, cur.wdata);
                mem_ready = (n == cur.lat);
                mem_rdata = mem_ready ? cur.mdata : $urandom;
            end else begin
                if (act) begin
                    check("mem_en_len", n, acc_cycles(cur));
                    check("idle_mem_we", mem_we, 0);
                    act = 1'b0;
                end
                // Stray mem_ready in IDLE must be ignored.
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks grants against predicted order and completions against the model.
    initial begin : monitor
        txn_t        t;
        int          gc;
        logic [31:0] last_rd  = '0;
        bit          last_err = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                last_rd  = '0;
                last_err = 1'b0;
            end else begin
                if (if_gnt || d_gnt) begin
                    check("gnt_onehot", if_gnt && d_gnt, 0);
                    if (gexp_q.size() == 0) check("gnt_unexpected", 1, 0);
                    else check("gnt_owner", d_gnt, gexp_q.pop_front());
                    gcyc_q.push_back(cyc);
                end
                if (if_rvalid || d_rvalid) begin
                    check("rvalid_onehot", if_rvalid && d_rvalid, 0);
                    if (exp_q.size() == 0) begin
                        check("rvalid_unexpected", 1, 0);
                    end else begin
                        t  = exp_q.pop_front();
                        gc = (gcyc_q.size() != 0) ? gcyc_q.pop_front() : -100;
                        check("rv_owner", d_rvalid, t.own);
                        check("rv_rdata", rdata, exp_rdata(t));
                        check("rv_err", err, t.lat > TO);
                        check("rv_latency", cyc, gc + acc_cycles(t) + 1);
                        last_rd  = exp_rdata(t);
                        last_err = (t.lat > TO);
                    end
                end else begin
                    check("rdata_err_hold", {err, rdata}, {last_err, last_rd});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin : stim
        int   w;
        int   gap;
        int   mode;
        txn_t dummy;
        txn_t td;
        dummy = mk(0, 0, 0, 0, 0, 1);
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        // Requests during reset must not be granted; outputs must be zero.
        if_req = 1'b1; d_req = 1'b1;
        @(negedge clock);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_outputs", {if_rvalid, d_rvalid, err, mem_en, mem_we}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(posedge clock); #1;
        if_req = 1'b0; d_req = 1'b0; reset = 1'b0;

        // Conflict from reset: expected order d, if, d, if.
        issue(1, 1, mk(0, 0, 32'h100, 0, 32'hA1, 1), mk(1, 0, 32'h200, 32'h5, 32'hB1, 2), w);
        issue(1, 1, mk(0, 0, 32'h104, 0, 32'hA2, 2), mk(1, 1, 32'h204, 32'h6, 32'hB2, 1), w);
        // Fetch read, first-cycle ready.
        issue(1, 0, mk(0, 0, 32'h10, 0, 32'h00500093, 1), dummy, w);
        // Write with ready on the third access cycle.
        issue(0, 1, dummy, mk(1, 1, 32'h40, 32'hDEADBEEF, 32'h12345678, 3), w);
        // Ready exactly on the last allowed cycle: success.
        issue(0, 1, dummy, mk(1, 0, 32'h44, 32'h0, 32'h0BADF00D, TO), w);
        // Timeout, then a normal fetch.
        issue(1, 0, mk(0, 0, 32'h50, 0, 32'h77777777, TO + 5), dummy, w);
        issue(1, 0, mk(0, 0, 32'h54, 0, 32'h13579BDF, 1), dummy, w);

        for (int r = 0; r < 200; r++) begin
            mode = int'($urandom % 3);
            issue(mode != 1, mode != 0, rnd_txn(1'b0), rnd_txn(1'b1), w);
            gap = int'($urandom % 4);
            repeat (gap) begin @(posedge clock); #1; end
        end
        drain();

        // Reset in the second access cycle with a data request held across it.
        issue(1, 0, mk(0, 0, 32'h20, 0, 32'h1, 10), dummy, w);   // returns in 1st access cycle
        td = mk(1, 0, 32'h80, 32'h55, 32'hCAFE0001, 2);
        d_req = 1'b1; d_we = td.we; d_addr = td.addr; d_wdata = td.wdata;
        @(posedge clock); #1;                                     // 2nd access cycle
        reset = 1'b1;
        exp_q.delete(); mem_q.delete(); gexp_q.delete(); gcyc_q.delete();
        m_last = 1'b0;
        @(negedge clock);
        check("rst_mid_d_gnt", d_gnt, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_mid_mem_en", mem_en, 0);
        check("rst_mid_rvalid", {if_rvalid, d_rvalid}, 0);
        check("rst_mid_d_gnt2", d_gnt, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        issue(0, 1, dummy, td, w);
        check("rst_regrant_wait", w, 1);
        drain();
        check("mem_q_empty", mem_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 16, maximum memory-access cycles before abort (legal range 2..255).
REQ-002 Ports SHALL be (name direction width meaning):
- clock in 1 system clock, rising edge
- reset in 1 synchronous, active-high reset
- if_req in 1 fetch request, held until if_gnt
- if_addr in ADDR_W fetch address
- if_gnt out 1 fetch request accepted this cycle
- if_rvalid out 1 fetch completion pulse
- d_req in 1 data request, held until d_gnt
- d_we in 1 data write enable
- d_addr in ADDR_W data address
- d_wdata in DATA_W data write value
- d_gnt out 1 data request accepted this cycle
- d_rvalid out 1 data completion pulse (read or write)
- rdata out DATA_W read data, valid with either rvalid
- err out 1 access timed out, valid with either rvalid
- mem_en out 1 memory access active
- mem_we out 1 memory write
- mem_addr out ADDR_W memory address
- mem_wdata out DATA_W memory write value
- mem_rdata in DATA_W memory read data, valid with mem_ready
- mem_ready in 1 memory completes access this cycle
REQ-003 The single clock SHALL be clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly two states: IDLE and ACCESS; only one access SHALL be outstanding at any time.
REQ-005 In IDLE with any request, the arbiter SHALL assert exactly one gnt combinationally in the same cycle, capture owner/addr/we/wdata (fetch: we=0, wdata=0), and enter ACCESS next cycle.
REQ-006 Single requester SHALL be granted immediately; on simultaneous requests the requester not granted most recently SHALL win (round-robin via last_owner register).
REQ-007 gnt SHALL never assert outside IDLE or during a reset cycle.
REQ-008 In ACCESS, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL hold the captured values, stable until exit; in IDLE mem_en, mem_we SHALL be 0.
REQ-009 On an ACCESS cycle with mem_ready=1: rdata SHALL register mem_rdata for reads or 0 for writes, err SHALL register 0, and the owner's rvalid SHALL pulse for exactly one cycle on the next cycle, when the FSM is back in IDLE.
REQ-010 Minimum latency: grant at cycle T, mem_en at T+1, rvalid at T+2; a new grant SHALL be possible in the rvalid cycle T+2.
REQ-011 A cycle counter SHALL count ACCESS cycles; if the TIMEOUT-th ACCESS cycle ends without mem_ready, the access SHALL abort: mem_en low next cycle, owner rvalid and err pulse one cycle, rdata=0, state IDLE.
REQ-012 mem_ready in IDLE SHALL be ignored; mem_ready on the TIMEOUT-th cycle SHALL count as success (err=0).
REQ-013 rdata and err SHALL hold their value between rvalid pulses; if_rvalid and d_rvalid SHALL never be high together.
REQ-014 A write SHALL complete with d_rvalid=1 as acknowledgement, identically to a read.

Reset
REQ-015 During reset, state SHALL go to IDLE, counter to 0, last_owner to fetch (data wins the first conflict), all outputs to 0 from the following cycle.
REQ-016 Reset in ACCESS SHALL abandon the access with no rvalid pulse; a request held through reset SHALL be granted in the first IDLE cycle after reset deasserts.

Verification
REQ-017 Fetch read: if_req, if_addr=0x10, mem_ready at first ACCESS cycle, mem_rdata=0x00500093 -> if_gnt at T, mem_en/mem_addr=0x10 at T+1, if_rvalid at T+2 with rdata=0x00500093, err=0.
REQ-018 Conflict: both requesting from reset, held -> grant order d, if, d, if; no cycle with both gnt high.
REQ-019 Write with delayed ready: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready after 3 ACCESS cycles -> mem_we=1, wdata stable 3 cycles, d_rvalid one cycle, rdata=0.
REQ-020 Timeout: TIMEOUT=16, mem_ready held 0 -> mem_en high exactly 16 cycles, then if_rvalid=1, err=1, rdata=0; next request served normally.
REQ-021 Reset mid-access: reset asserted in 2nd ACCESS cycle -> mem_en=0 next cycle, no rvalid pulse; held d_req granted in first cycle after reset release.
